write_reg_pipe: RTL and testbench
=================================

WRITE_REG_PIPE -- requirements
Module: write_reg_pipe

Interface
REQ-001 Parameter: AW, default 5, register-address width; all address ports are AW bits wide.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ex_waddr  input  AW  EX-stage write register, as chosen by the rt/rd write-register select.
REQ-005 ex_regwrite  input  1  EX-stage instruction writes the register file.
REQ-006 ex_memread  input  1  EX-stage instruction is a load.
REQ-007 ex_rs, ex_rt  input  AW each  EX-stage source registers, used for forwarding.
REQ-008 id_rs, id_rt  input  AW each  ID-stage source registers, used for hazard detection.
REQ-009 id_uses_rt  input  1  ID-stage instruction reads rt as a source.
REQ-010 flush  input  1  squash the EX-stage instruction; a bubble enters EX/MEM.
REQ-011 freeze  input  1  global hold; EX/MEM and MEM/WB keep their contents.
REQ-012 mem_waddr, wb_waddr  output  AW each  EX/MEM and MEM/WB write addresses.
REQ-013 mem_regwrite, wb_regwrite  output  1 each  qualified write enables for MEM and WB.
REQ-014 mem_memread  output  1  the MEM-stage instruction is a load.
REQ-015 fwd_a, fwd_b  output  2 each  forwarding select for ALU operands A (rs) and B (rt).
REQ-016 load_use_stall  output  1  stall request to the PC, IF/ID and ID/EX bubble logic.
REQ-017 stall_cnt  output  8  saturating count of load-use stall cycles since reset.

Function
REQ-018 Valid write (qualified): ex_regwrite=1 and ex_waddr != 0; a write to $0 is never valid.
REQ-019 Each edge with freeze=0, EX/MEM captures:
- waddr <= ex_waddr;
- regwrite <= valid write AND NOT flush;
- memread <= ex_memread AND NOT flush.
REQ-020 Each edge with freeze=0, MEM/WB captures the EX/MEM waddr and regwrite.
REQ-021 With freeze=1, all pipeline registers and stall_cnt hold their values; freeze takes priority over flush.
REQ-022 Latency:
- ex_waddr appears on mem_waddr 1 cycle later and on wb_waddr 2 cycles later.
- No bypass from input to output.
REQ-023 fwd_a encoding:
- 2'b10 when mem_regwrite=1 and mem_waddr == ex_rs;
- else 2'b01 when wb_regwrite=1 and wb_waddr == ex_rs;
- else 2'b00.
REQ-024 fwd_b: same rule as REQ-023, using ex_rt.
REQ-025 When MEM and WB both match, MEM wins (2'b10).
REQ-026 Forwarding outputs are combinational from the registered state and the ex_rs/ex_rt inputs.
REQ-027 load_use_stall = ex_memread AND valid write AND NOT flush AND (ex_waddr == id_rs OR (id_uses_rt AND ex_waddr == id_rt)); combinational.
REQ-028 stall_cnt:
- increments by 1 on each edge where load_use_stall=1 and freeze=0;
- saturates at 255 and never wraps.
REQ-029 A flush in the same cycle as a load-use match suppresses the stall, and the bubble is written.
REQ-030 mem_memread never forwards; a load's data is forwarded only from WB, which the stall guarantees.

Reset
REQ-031 reset=0 asynchronously clears, independent of clk: mem_waddr, wb_waddr, mem_regwrite, wb_regwrite, mem_memread and stall_cnt.
REQ-032 While reset=0: fwd_a = fwd_b = 2'b00, and load_use_stall follows its inputs per REQ-027.
REQ-033 Reset asserted mid-operation discards in-flight writes; the first edge after release captures normally.

Verification
REQ-034 R-type with ex_waddr=5, regwrite=1, then next instruction ex_rs=5 -> fwd_a=2'b10; one cycle later ex_rs=5 -> fwd_a=2'b01; third cycle -> 2'b00.
REQ-035 ex_waddr=0, regwrite=1, following ex_rs=0 -> mem_regwrite=0, fwd_a=2'b00.
REQ-036 Load ex_waddr=8 with id_rt=8, id_uses_rt=1 -> load_use_stall=1 and stall_cnt increments; same with id_uses_rt=0 and id_rs=3 -> load_use_stall=0.
REQ-037 Back-to-back writes to $9 (older now in WB, newer in MEM), ex_rt=9 -> fwd_b=2'b10; flush on the newer -> fwd_b=2'b01.
REQ-038 freeze=1 for 3 cycles with mem_waddr=4 -> mem_waddr and wb_waddr unchanged, stall_cnt unchanged even with load_use_stall=1.
REQ-039 Force 260 stall cycles -> stall_cnt=255; assert reset between edges -> all registered outputs 0 immediately.

Source files
------------

// File: rtl/write_reg_pipe.sv
// EX/MEM and MEM/WB write-register tracking with operand forwarding selects,
// load-use stall detection and a saturating stall-cycle counter.
module write_reg_pipe #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ex_waddr,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic          flush,
    input  logic          freeze,
    output logic [AW-1:0] mem_waddr,
    output logic [AW-1:0] wb_waddr,
    output logic          mem_regwrite,
    output logic          wb_regwrite,
    output logic          mem_memread,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          load_use_stall,
    output logic [7:0]    stall_cnt
);

    logic [AW-1:0] r_mem_waddr, r_wb_waddr;
    logic          r_mem_we, r_wb_we, r_mem_rd;
    logic [7:0]    r_stall_cnt;
    logic          w_valid_wr;
    logic          w_lu_match;
    logic          w_stall;

    // Writes to register 0 are architecturally discarded, so never qualify them.
    assign w_valid_wr = ex_regwrite && (ex_waddr != '0);
    assign w_lu_match = (ex_waddr == id_rs) || (id_uses_rt && (ex_waddr == id_rt));
    assign w_stall    = ex_memread && w_valid_wr && !flush && w_lu_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_waddr <= '0;
            r_mem_we    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_wb_waddr  <= '0;
            r_wb_we     <= 1'b0;
            r_stall_cnt <= 8'd0;
        end else if (!freeze) begin
            r_mem_waddr <= ex_waddr;
            r_mem_we    <= w_valid_wr && !flush;
            r_mem_rd    <= ex_memread && !flush;
            r_wb_waddr  <= r_mem_waddr;
            r_wb_we     <= r_mem_we;
            if (w_stall && (r_stall_cnt != 8'hFF))
                r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    // MEM has priority over WB; loads in MEM are covered by the stall, so no memread gating.
    always_comb begin
        fwd_a = 2'b00;
        if (r_mem_we && (r_mem_waddr == ex_rs))     fwd_a = 2'b10;
        else if (r_wb_we && (r_wb_waddr == ex_rs))  fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (r_mem_we && (r_mem_waddr == ex_rt))     fwd_b = 2'b10;
        else if (r_wb_we && (r_wb_waddr == ex_rt))  fwd_b = 2'b01;
    end

    assign mem_waddr      = r_mem_waddr;
    assign wb_waddr       = r_wb_waddr;
    assign mem_regwrite   = r_mem_we;
    assign wb_regwrite    = r_wb_we;
    assign mem_memread    = r_mem_rd;
    assign load_use_stall = w_stall;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_write_reg_pipe.sv
// Bench for write_reg_pipe: directed vector table, stall saturation and
// mid-cycle reset sequences, then random stimulus against a queue-based model.
module tb_write_reg_pipe;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ex_waddr, ex_rs, ex_rt, id_rs, id_rt;
    logic          ex_regwrite, ex_memread, id_uses_rt, flush, freeze;
    logic [AW-1:0] mem_waddr, wb_waddr;
    logic          mem_regwrite, wb_regwrite, mem_memread, load_use_stall;
    logic [1:0]    fwd_a, fwd_b;
    logic [7:0]    stall_cnt;

    write_reg_pipe #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .ex_waddr(ex_waddr), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .flush(flush), .freeze(freeze), .mem_waddr(mem_waddr),
        .wb_waddr(wb_waddr), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_memread(mem_memread), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of retired EX entries, newest first.
    typedef struct { int waddr; bit we; bit rd; } ent_t;
    ent_t hist[$];
    int   cnt_raw;

    function automatic void model_reset();
        ent_t z = '{0, 1'b0, 1'b0};
        hist = {};
        hist.push_back(z);
        hist.push_back(z);
        cnt_raw = 0;
    endfunction

    function automatic bit m_valid();
        return ex_regwrite && (int'(ex_waddr) != 0);
    endfunction

    function automatic bit m_stall();
        return ex_memread && m_valid() && !flush &&
               (ex_waddr == id_rs || (id_uses_rt && ex_waddr == id_rt));
    endfunction

    function automatic int m_fwd(input int src);
        if (hist[0].we && hist[0].waddr == src) return 2;
        if (hist[1].we && hist[1].waddr == src) return 1;
        return 0;
    endfunction

    function automatic void model_edge();
        ent_t e;
        if (freeze) return;
        e.waddr = int'(ex_waddr);
        e.we    = m_valid() && !flush;
        e.rd    = ex_memread && !flush;
        if (m_stall()) cnt_raw++;
        hist.push_front(e);
        void'(hist.pop_back());
    endfunction

    task automatic check_comb();
        chk("fwd_a", 32'(fwd_a), 32'(m_fwd(int'(ex_rs))));
        chk("fwd_b", 32'(fwd_b), 32'(m_fwd(int'(ex_rt))));
        chk("load_use_stall", 32'(load_use_stall), 32'(m_stall()));
    endtask

    task automatic check_regs();
        chk("mem_waddr", 32'(mem_waddr), 32'(hist[0].waddr));
        chk("mem_regwrite", 32'(mem_regwrite), 32'(hist[0].we));
        chk("mem_memread", 32'(mem_memread), 32'(hist[0].rd));
        chk("wb_waddr", 32'(wb_waddr), 32'(hist[1].waddr));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(hist[1].we));
        chk("stall_cnt", 32'(stall_cnt), 32'(cnt_raw > 255 ? 255 : cnt_raw));
    endtask

    // Inputs are already driven; check comb outputs, clock once, check state.
    task automatic step();
        #1 check_comb();
        @(posedge clk);
        model_edge();
        #1 check_regs();
    endtask

    task automatic drive(input int wa, input bit rw, input bit mr, input int rs, input int rt,
                         input int irs, input int irt, input bit use_rt, input bit fl, input bit fz);
        ex_waddr = AW'(wa); ex_regwrite = rw; ex_memread = mr; ex_rs = AW'(rs); ex_rt = AW'(rt);
        id_rs = AW'(irs); id_rt = AW'(irt); id_uses_rt = use_rt; flush = fl; freeze = fz;
    endtask

    // Async reset between edges: outputs must clear without a clock edge.
    task automatic mid_reset();
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("rst mem_waddr", 32'(mem_waddr), 32'd0);
        chk("rst wb_waddr", 32'(wb_waddr), 32'd0);
        chk("rst mem_regwrite", 32'(mem_regwrite), 32'd0);
        chk("rst wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("rst mem_memread", 32'(mem_memread), 32'd0);
        chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst fwd_a", 32'(fwd_a), 32'd0);
        chk("rst fwd_b", 32'(fwd_b), 32'd0);
        chk("rst load_use_stall", 32'(load_use_stall), 32'(m_stall()));
        #1 reset = 1'b1;
    endtask

    typedef struct {
        int wa; bit rw, mr; int rs, rt, irs, irt; bit use_rt, fl, fz;
        int fa, fb; bit lus;
        int mwa; bit mwe, mrd; int wwa; bit wwe; int cnt;
    } vec_t;
    vec_t tbl[18];

    initial begin
        // wa rw mr rs rt irs irt use fl fz | fa fb lus | mwa mwe mrd wwa wwe cnt
        tbl[0]  = '{5,1,0, 0,0, 0,0,0,0,0,  0,0,0,  5,1,0, 0,0,0};
        tbl[1]  = '{6,0,0, 5,0, 0,0,0,0,0,  2,0,0,  6,0,0, 5,1,0};
        tbl[2]  = '{0,1,0, 5,0, 0,0,0,0,0,  1,0,0,  0,0,0, 6,0,0};
        tbl[3]  = '{7,0,0, 5,0, 0,0,0,0,0,  0,0,0,  7,0,0, 0,0,0};
        tbl[4]  = '{8,1,1, 0,0, 3,8,1,0,0,  0,0,1,  8,1,1, 7,0,1};
        tbl[5]  = '{8,1,1, 0,0, 3,8,0,0,0,  0,0,0,  8,1,1, 8,1,1};
        tbl[6]  = '{9,1,0, 0,0, 0,0,0,0,0,  0,0,0,  9,1,0, 8,1,1};
        tbl[7]  = '{9,1,0, 8,9, 0,0,0,0,0,  1,2,0,  9,1,0, 9,1,1};
        tbl[8]  = '{0,0,0, 0,9, 0,0,0,0,0,  0,2,0,  0,0,0, 9,1,1};
        tbl[9]  = '{9,1,0, 0,0, 0,0,0,0,0,  0,0,0,  9,1,0, 0,0,1};
        tbl[10] = '{9,1,0, 0,9, 0,0,0,1,0,  0,2,0,  9,0,0, 9,1,1};
        tbl[11] = '{0,0,0, 0,9, 0,0,0,0,0,  0,1,0,  0,0,0, 9,0,1};
        tbl[12] = '{8,1,1, 0,0, 8,0,0,1,0,  0,0,0,  8,0,0, 0,0,1};
        tbl[13] = '{4,1,0, 0,0, 0,0,0,0,0,  0,0,0,  4,1,0, 8,0,1};
        tbl[14] = '{8,1,1, 0,0, 8,0,0,0,1,  0,0,1,  4,1,0, 8,0,1};
        tbl[15] = '{8,1,1, 0,0, 8,0,0,0,1,  0,0,1,  4,1,0, 8,0,1};
        tbl[16] = '{8,1,1, 0,0, 8,0,0,1,1,  0,0,0,  4,1,0, 8,0,1};
        tbl[17] = '{0,0,0, 4,0, 0,0,0,0,0,  2,0,0,  0,0,0, 4,1,1};

        // Reset state, with a load-use match present to show the stall stays combinational.
        reset = 1'b0;
        drive(8, 1, 1, 0, 0, 8, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init mem_waddr", 32'(mem_waddr), 32'd0);
        chk("init wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("init stall_cnt", 32'(stall_cnt), 32'd0);
        chk("init fwd_a", 32'(fwd_a), 32'd0);
        chk("init load_use_stall", 32'(load_use_stall), 32'd1);
        @(negedge clk) reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].wa, tbl[i].rw, tbl[i].mr, tbl[i].rs, tbl[i].rt,
                  tbl[i].irs, tbl[i].irt, tbl[i].use_rt, tbl[i].fl, tbl[i].fz);
            #1;
            chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
            chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
            chk($sformatf("v%0d lus", i), 32'(load_use_stall), 32'(tbl[i].lus));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("v%0d mem_waddr", i), 32'(mem_waddr), 32'(tbl[i].mwa));
            chk($sformatf("v%0d mem_regwrite", i), 32'(mem_regwrite), 32'(tbl[i].mwe));
            chk($sformatf("v%0d mem_memread", i), 32'(mem_memread), 32'(tbl[i].mrd));
            chk($sformatf("v%0d wb_waddr", i), 32'(wb_waddr), 32'(tbl[i].wwa));
            chk($sformatf("v%0d wb_regwrite", i), 32'(wb_regwrite), 32'(tbl[i].wwe));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
        end

        // Saturation: 260 more stall cycles must pin the counter at 255.
        drive(8, 1, 1, 0, 0, 8, 0, 0, 0, 0);
        repeat (260) step();
        chk("sat stall_cnt", 32'(stall_cnt), 32'd255);
        mid_reset();
        step();
        chk("post-reset stall_cnt", 32'(stall_cnt), 32'd1);

        // Random phase: small address space to provoke matches.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            step();
            if ($urandom_range(0, 59) == 0) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
